// File: rtl/multi_flux_pick_accum.sv
// multi_flux_pick_accum: N-flux tagged dataflow actor.
// Incoming {tag, data} tokens are demultiplexed into per-flux FIFOs. A shared
// firing engine picks an eligible flux round-robin, pops the rate-defined
// number of tokens, and emits their modular sum tagged with that flux.
module multi_flux_pick_accum #(
  parameter int FLUX       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = $clog2(FLUX),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int DEPTH      = 4,
  parameter int MODE       = 0,
  parameter int RATE0      = 4,
  parameter int RATE1      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_port_write,
  input  logic [WIDTH-1:0] in_port_datain,
  output logic [FLUX-1:0]  in_port_full,
  output logic             out_port_write,
  output logic [WIDTH-1:0] out_port_dataout,
  input  logic             out_port_full,
  output logic             err_port
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0]        DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]        RATE0_C  = CW'(RATE0);
  localparam logic [CW-1:0]        RATE1_C  = CW'(RATE1);
  localparam logic [TAG_WIDTH:0]   FLUX_C   = (TAG_WIDTH + 1)'(FLUX);
  localparam logic [TAG_WIDTH-1:0] LAST_C   = TAG_WIDTH'(FLUX - 1);

  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem    [FLUX][DEPTH];
  logic [PW-1:0]         wr_ptr [FLUX];
  logic [PW-1:0]         rd_ptr [FLUX];
  logic [CW-1:0]         count  [FLUX];

  logic [FLUX-1:0]       phase;
  logic [TAG_WIDTH-1:0]  rr_ptr;
  logic [TAG_WIDTH-1:0]  sel;
  logic [CW-1:0]         n_left;
  logic [DATA_WIDTH-1:0] acc;

  logic [TAG_WIDTH-1:0]  in_tag;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  tag_ok;
  logic [FLUX-1:0]       push;
  logic [FLUX-1:0]       pop;

  logic                  hit;
  logic [TAG_WIDTH-1:0]  hit_idx;
  logic [CW-1:0]         hit_rate;
  logic [TAG_WIDTH-1:0]  cand;
  int unsigned           idx;

  function automatic logic [CW-1:0] rate_of(input logic ph);
    if (MODE == 1 && ph) return RATE1_C;
    return RATE0_C;
  endfunction

  assign in_tag  = in_port_datain[WIDTH-1:DATA_WIDTH];
  assign in_data = in_port_datain[DATA_WIDTH-1:0];
  assign tag_ok  = ({1'b0, in_tag} < FLUX_C);

  // Full flags, push/pop strobes per flux; full is taken from the pre-edge count
  always_comb begin
    in_port_full = '0;
    push         = '0;
    pop          = '0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      in_port_full[f] = (count[f] == DEPTH_C);
      push[f] = in_port_write && tag_ok && (in_tag == TAG_WIDTH'(f)) &&
                (count[f] != DEPTH_C);
      pop[f]  = (state == ACC) && (sel == TAG_WIDTH'(f));
    end
  end

  // Round-robin search for the first flux holding at least its current rate
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_rate = RATE0_C;
    idx      = 0;
    cand     = '0;
    for (int unsigned i = 0; i < FLUX; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= FLUX) idx = idx - FLUX;
      cand = TAG_WIDTH'(idx);
      if (!hit && (count[cand] >= rate_of(phase[cand]))) begin
        hit      = 1'b1;
        hit_idx  = cand;
        hit_rate = rate_of(phase[cand]);
      end
    end
  end

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    for (int unsigned f = 0; f < FLUX; f++) begin
      if (push[f]) mem[f][wr_ptr[f]] <= in_data;
    end
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned f = 0; f < FLUX; f++) begin
        wr_ptr[f] <= '0;
        rd_ptr[f] <= '0;
        count[f]  <= '0;
      end
    end else begin
      for (int unsigned f = 0; f < FLUX; f++) begin
        if (push[f]) wr_ptr[f] <= wr_ptr[f] + 1'b1;
        if (pop[f])  rd_ptr[f] <= rd_ptr[f] + 1'b1;
        case ({push[f], pop[f]})
          2'b10:   count[f] <= count[f] + 1'b1;
          2'b01:   count[f] <= count[f] - 1'b1;
          default: count[f] <= count[f];
        endcase
      end
    end
  end

  // Firing engine: select flux, accumulate n pops, emit tagged sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      sel              <= '0;
      rr_ptr           <= '0;
      acc              <= '0;
      n_left           <= '0;
      phase            <= '0;
      out_port_write   <= 1'b0;
      out_port_dataout <= '0;
    end else begin
      out_port_write <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            sel    <= hit_idx;
            acc    <= '0;
            n_left <= hit_rate;
            state  <= ACC;
          end
        end
        ACC: begin
          acc    <= acc + mem[sel][rd_ptr[sel]];
          n_left <= n_left - 1'b1;
          if (n_left == CW'(1)) state <= EMIT;
        end
        EMIT: begin
          if (!out_port_full) begin
            out_port_write   <= 1'b1;
            out_port_dataout <= {sel, acc};
            if (MODE == 1) phase[sel] <= ~phase[sel];
            rr_ptr <= (sel == LAST_C) ? '0 : sel + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky bad-tag flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_port <= 1'b0;
    end else if (in_port_write && !tag_ok) begin
      err_port <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multi_flux_pick_accum.sv
// Directed bench for multi_flux_pick_accum: four configurations share one
// clock and reset; emitted tokens are captured into per-instance queues.
module tb_multi_flux_pick_accum;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // a: FLUX=2 DEPTH=8 SDF RATE0=4
  logic       a_wr = 1'b0, a_ofull = 1'b0, a_owr, a_err;
  logic [8:0] a_din = '0, a_dout;
  logic [1:0] a_full;
  // b: FLUX=2 DEPTH=4 SDF RATE0=4
  logic       b_wr = 1'b0, b_ofull = 1'b0, b_owr, b_err;
  logic [8:0] b_din = '0, b_dout;
  logic [1:0] b_full;
  // c: FLUX=2 DEPTH=4 CSDF RATE0=1 RATE1=3
  logic       c_wr = 1'b0, c_ofull = 1'b0, c_owr, c_err;
  logic [8:0] c_din = '0, c_dout;
  logic [1:0] c_full;
  // d: FLUX=3 DEPTH=4 SDF RATE0=4
  logic       d_wr = 1'b0, d_ofull = 1'b0, d_owr, d_err;
  logic [9:0] d_din = '0, d_dout;
  logic [2:0] d_full;

  multi_flux_pick_accum #(.FLUX(2), .DATA_WIDTH(8), .DEPTH(8), .MODE(0), .RATE0(4), .RATE1(2)) u_a (
    .clk(clk), .rst(rst), .in_port_write(a_wr), .in_port_datain(a_din), .in_port_full(a_full),
    .out_port_write(a_owr), .out_port_dataout(a_dout), .out_port_full(a_ofull), .err_port(a_err));
  multi_flux_pick_accum #(.FLUX(2), .DATA_WIDTH(8), .DEPTH(4), .MODE(0), .RATE0(4), .RATE1(2)) u_b (
    .clk(clk), .rst(rst), .in_port_write(b_wr), .in_port_datain(b_din), .in_port_full(b_full),
    .out_port_write(b_owr), .out_port_dataout(b_dout), .out_port_full(b_ofull), .err_port(b_err));
  multi_flux_pick_accum #(.FLUX(2), .DATA_WIDTH(8), .DEPTH(4), .MODE(1), .RATE0(1), .RATE1(3)) u_c (
    .clk(clk), .rst(rst), .in_port_write(c_wr), .in_port_datain(c_din), .in_port_full(c_full),
    .out_port_write(c_owr), .out_port_dataout(c_dout), .out_port_full(c_ofull), .err_port(c_err));
  multi_flux_pick_accum #(.FLUX(3), .DATA_WIDTH(8), .DEPTH(4), .MODE(0), .RATE0(4), .RATE1(2)) u_d (
    .clk(clk), .rst(rst), .in_port_write(d_wr), .in_port_datain(d_din), .in_port_full(d_full),
    .out_port_write(d_owr), .out_port_dataout(d_dout), .out_port_full(d_ofull), .err_port(d_err));

  logic [9:0] qa[$], qb[$], qc[$], qd[$];
  int checks = 0;
  int passes = 0;
  int consec = 0;
  logic pa = 1'b0, pb = 1'b0, pc = 1'b0, pd = 1'b0;

  // Capture emitted tokens and flag back-to-back strobes
  always @(negedge clk) begin
    if (a_owr) qa.push_back({1'b0, a_dout});
    if (b_owr) qb.push_back({1'b0, b_dout});
    if (c_owr) qc.push_back({1'b0, c_dout});
    if (d_owr) qd.push_back(d_dout);
    if ((a_owr && pa) || (b_owr && pb) || (c_owr && pc) || (d_owr && pd)) consec++;
    pa = a_owr; pb = b_owr; pc = c_owr; pd = d_owr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One write cycle to instance d (0..3), starting and ending at a negedge
  task automatic put(input int d, input int tag, input int data);
    case (d)
      0: begin a_din = {tag[0], data[7:0]};   a_wr = 1'b1; end
      1: begin b_din = {tag[0], data[7:0]};   b_wr = 1'b1; end
      2: begin c_din = {tag[0], data[7:0]};   c_wr = 1'b1; end
      default: begin d_din = {tag[1:0], data[7:0]}; d_wr = 1'b1; end
    endcase
    @(negedge clk);
    a_wr = 1'b0; b_wr = 1'b0; c_wr = 1'b0; d_wr = 1'b0;
  endtask

  function automatic int qsize(input int d);
    case (d)
      0: return qa.size();
      1: return qb.size();
      2: return qc.size();
      default: return qd.size();
    endcase
  endfunction

  // Bounded wait for n captured outputs; caller checks the size afterwards
  task automatic wait_out(input int d, input int n);
    for (int k = 0; k < 300; k++) begin
      if (qsize(d) >= n) break;
      @(negedge clk);
    end
  endtask

  int tags[16] = '{0,1,1,0,0,0,0,1,0,1,1,0,1,1,1,0};
  int n004, n104;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_full", {a_full, d_full}, 32'h0);
    check("rst_owr", {a_owr, b_owr, c_owr, d_owr}, 32'h0);
    check("rst_dout_a", a_dout, 32'h0);
    check("rst_dout_d", d_dout, 32'h0);
    check("rst_err", {a_err, d_err}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Interleaved stream, one cycle of backpressure mid-stream
    for (int i = 0; i < 16; i++) begin
      a_ofull = (i == 8);
      put(0, tags[i], 1);
    end
    a_ofull = 1'b0;
    wait_out(0, 4);
    repeat (20) @(negedge clk);
    n004 = 0; n104 = 0;
    foreach (qa[i]) begin
      if (qa[i] == 10'h004) n004++;
      if (qa[i] == 10'h104) n104++;
    end
    check("stream_count", qa.size(), 4);
    check("stream_f0", n004, 2);
    check("stream_f1", n104, 2);
    qa.delete();

    // Modular wrap of the sum
    repeat (4) put(0, 1, 8'h80);
    wait_out(0, 1);
    check("wrap_count", qa.size(), 1);
    check("wrap_val", qa[0], 10'h100);
    qa.delete();

    // Round-robin with both fluxes backed up behind a stalled emit
    a_ofull = 1'b1;
    repeat (4) put(0, 0, 1);
    repeat (8) put(0, 1, 2);
    repeat (4) put(0, 0, 1);
    repeat (4) @(negedge clk);
    check("rr_stalled", qa.size(), 0);
    check("rr_full1", a_full[1], 1'b1);
    a_ofull = 1'b0;
    wait_out(0, 4);
    check("rr_count", qa.size(), 4);
    check("rr_seq0", qa[0], 10'h004);
    check("rr_seq1", qa[1], 10'h108);
    check("rr_seq2", qa[2], 10'h004);
    check("rr_seq3", qa[3], 10'h108);

    // Full flag and drop on a depth-4 FIFO
    b_ofull = 1'b1;
    repeat (4) put(1, 1, 1);
    repeat (8) @(negedge clk);
    put(1, 0, 1); put(1, 0, 2); put(1, 0, 3);
    check("full_before", b_full[0], 1'b0);
    put(1, 0, 4);
    check("full_after4", b_full[0], 1'b1);
    put(1, 0, 5);
    check("full_after5", b_full[0], 1'b1);
    check("full_stalled", qb.size(), 0);
    b_ofull = 1'b0;
    wait_out(1, 2);
    check("drop_count", qb.size(), 2);
    check("drop_f1", qb[0], 10'h104);
    check("drop_f0", qb[1], 10'h00A);
    check("drop_empty", b_full, 2'b00);

    // CSDF alternating rates 1,3,1
    put(2, 0, 2); put(2, 0, 3); put(2, 0, 4); put(2, 0, 5);
    wait_out(2, 2);
    check("csdf_count", qc.size(), 2);
    check("csdf_p0", qc[0], 10'h002);
    check("csdf_p1", qc[1], 10'h00C);
    put(2, 0, 7);
    wait_out(2, 3);
    check("csdf_back_p0", qc.size() == 3 ? qc[2] : 10'h3FF, 10'h007);

    // Three fluxes, bad tag, reset mid-accumulate
    repeat (4) put(3, 2, 1);
    wait_out(3, 1);
    check("f3_val", qd.size() == 1 ? qd[0] : 10'h3FF, 10'h204);
    check("err_before", d_err, 1'b0);
    put(3, 3, 9);
    check("err_set", d_err, 1'b1);
    check("err_full", d_full, 3'b000);
    for (int f = 0; f < 3; f++) repeat (3) put(3, f, 5);
    repeat (20) @(negedge clk);
    check("badtag_nofire", qd.size(), 1);
    check("dout_hold", d_dout, 10'h204);
    put(3, 0, 5);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_err", d_err, 1'b0);
    check("arst_dout", d_dout, 10'h000);
    check("arst_owr", d_owr, 1'b0);
    check("arst_full", d_full, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("arst_no_emit", qd.size(), 1);

    check("no_consec_write", consec, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_flux_pick_accum.md
# multi_flux_pick_accum

Parametrised N-flux tagged dataflow actor that buffers each flux in its own FIFO and runs a shared SDF/CSDF accumulate firing engine. Each firing consumes the rate-defined number of tokens from one flux and emits their sum tagged with that flux. The block sits between a tagged producer and a single tagged consumer port. It generalises the 1-port/2-flux PICK wrapper to FLUX channels, configurable FIFO depth, a selectable SDF/CSDF mode, round-robin flux fairness and bad-tag detection.

## Interface
- FLUX, 4, number of fluxes (≥2)
- DATA_WIDTH, 8, payload width
- TAG_WIDTH, $clog2(FLUX), tag width; occupies the MSBs of every token
- WIDTH, DATA_WIDTH+TAG_WIDTH, token width
- DEPTH, 4, per-flux FIFO depth; power of 2, ≥2
- MODE, 0, 0 = SDF (every firing uses RATE0); 1 = CSDF (per-flux firings alternate RATE0, RATE1)
- RATE0, 4, tokens per firing in SDF mode, and in CSDF phase 0; range 1..DEPTH
- RATE1, 2, tokens per firing in CSDF phase 1; range 1..DEPTH
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_port_write  in  1  input token valid
- in_port_datain  in  WIDTH  {tag, data}
- in_port_full  out  FLUX  bit f set = FIFO f holds DEPTH tokens
- out_port_write  out  1  output token strobe, one cycle per token
- out_port_dataout  out  WIDTH  {flux tag, sum}
- out_port_full  in  1  consumer backpressure
- err_port  out  1  sticky flag: a token arrived with tag ≥ FLUX

## Operation
- Demux: tag = in_port_datain[WIDTH-1:DATA_WIDTH].
  - Write with tag f < FLUX and !in_port_full[f]: data pushed into FIFO f.
  - Write to a full FIFO: token silently dropped. The producer must check in_port_full.
  - Tag ≥ FLUX: token dropped and err_port set. err_port clears only on reset.
- Per-flux state: FIFO (count 0..DEPTH, wrapping read/write pointers) and CSDF phase bit. The phase bit is unused when MODE = 0.
- Current rate of flux f: RATE0 if MODE = 0, or if MODE = 1 and phase = 0; otherwise RATE1.
- FSM states: IDLE, ACC, EMIT.
  - IDLE: search for fluxes with count ≥ current rate, starting at rr_ptr and wrapping. First hit becomes sel; load acc = 0 and n = rate(sel); go to ACC. No hit: stay in IDLE.
  - ACC: pop one token from FIFO sel per cycle; acc = acc + data, modulo 2^DATA_WIDTH. After n pops go to EMIT.
  - EMIT: if !out_port_full, drive out_port_write = 1 and out_port_dataout = {sel, acc}. Then toggle phase[sel] (CSDF only), set rr_ptr = (sel+1) mod FLUX, and return to IDLE. If out_port_full, hold in EMIT with acc retained.
- Push and pop on the same FIFO in the same cycle are both performed; count is unchanged.
- in_port_full[f] reflects count at the start of the cycle. A pop in that cycle does not admit a push to a full FIFO.
- Reset, whether idle or mid-firing:
  - FIFOs emptied, partial acc discarded.
  - Phases = 0, rr_ptr = 0, FSM = IDLE.
  - All outputs = 0.

## Timing
- Reset values: in_port_full = 0, out_port_write = 0, out_port_dataout = 0, err_port = 0.
- A token written in cycle t is visible in count, and in in_port_full, at cycle t+1.
- A flux becomes eligible in IDLE at cycle t. Pops occur in cycles t+1..t+n. out_port_write is asserted at t+n+1 if out_port_full is low at that edge.
- Minimum firing period: n+2 cycles.
- out_port_write is never asserted in consecutive cycles. out_port_dataout holds its last value when out_port_write = 0.
- out_port_full is sampled only in EMIT. Assertion during IDLE or ACC does not stall popping.
- err_port is set at the edge after the bad-tag write.

## Test plan
- Defaults with FLUX=2, MODE=0, RATE0=4, DEPTH=8. Stimulus: 8 tokens of data 1 per flux, interleaved 0,1,1,0,0,0,0,1,0,1,1,0,1,1,1,0, with out_port_full high for one cycle mid-stream. Required: exactly four outputs, 0x004 ×2 and 0x104 ×2, with no token lost.
- Full and drop, DEPTH=4. Hold out_port_full = 1 while an earlier firing is in EMIT, then write 5 tokens to flux 0. Required: in_port_full[0] = 1 one cycle after the 4th write; the 5th token is dropped; after release the next flux-0 output sums only the 4 buffered tokens.
- CSDF, MODE=1, RATE0=1, RATE1=3. Flux 0 receives 2,3,4,5. Required: outputs {0,2}, then {0,12}; phase[0] returns to 0.
- Wrap-around: four tokens of 0x80 on flux 1 with RATE0=4. Required: output {1,0x00}.
- Round-robin: both fluxes hold ≥ RATE0 tokens at the same time. Required: outputs alternate 0,1,0,1.
- Bad tag: FLUX=3, TAG_WIDTH=2, write tag 3. Required: err_port = 1 next cycle, no FIFO count change. Then async reset mid-ACC: all outputs 0 immediately and the partial sum is never emitted.
